// File: rtl/player_anim_ctrl_pkg.sv
// Shared encodings for the player animation sequencer and related animators.
package player_anim_ctrl_pkg;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam int unsigned FRAMES_PER_DIR = 4;
  localparam int unsigned FRAME_W        = $clog2(FRAMES_PER_DIR);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    DYING = 2'd1,
    DEAD  = 2'd2,
    SPAWN = 2'd3
  } life_state_e;

  // Sprite ROM frame index: direction selects the row, frame the column.
  function automatic logic [3:0] frame_index(input logic [1:0] d,
                                             input logic [FRAME_W-1:0] f);
    return {d, f};
  endfunction

endpackage

// File: rtl/player_anim_ctrl_tick_gen.sv
// Free-running animation step generator: one-cycle tick every TICK_DIV clocks.
module anim_tick_gen #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap to zero after the terminal value.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  assign tick = (cnt_q == LAST);

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/player_anim_ctrl.sv
// Per-player sprite frame and life-state sequencer (walk, death flash,
// dead hold, respawn invulnerability).
module player_anim_ctrl
  import player_anim_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 5000000,
  parameter int unsigned DEATH_TICKS = 8,
  parameter int unsigned SPAWN_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir,
  input  logic       moving,
  input  logic       hit,
  input  logic       revive,
  output logic [3:0] state,
  output logic       is_dead,
  output logic       invuln,
  output logic       alive
);

  localparam int unsigned MAX_TICKS = (DEATH_TICKS > SPAWN_TICKS) ? DEATH_TICKS : SPAWN_TICKS;
  localparam int unsigned PW        = $clog2(MAX_TICKS) + 1;
  localparam logic [PW-1:0] DEATH_END  = PW'(DEATH_TICKS);
  localparam logic [PW-1:0] SPAWN_LAST = PW'(SPAWN_TICKS - 1);

  life_state_e          fsm_q, fsm_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [1:0]           dir_q, dir_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 is_dead_q, is_dead_d;
  logic                 invuln_q, invuln_d;
  logic                 alive_q, alive_d;

  logic                 tick;
  logic [FRAME_W-1:0]   walk_frame;
  logic [1:0]           walk_dir;

  anim_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Walk animation candidate: idle resets frame, a turn restarts at frame 0
  // (taking priority over a tick), otherwise advance one frame per tick.
  always_comb begin
    walk_dir   = dir_q;
    walk_frame = frame_q;
    if (!moving) begin
      walk_frame = '0;
    end else if (dir != dir_q) begin
      walk_dir   = dir;
      walk_frame = '0;
    end else if (tick) begin
      walk_frame = frame_q + FRAME_W'(1);
    end
  end

  // Life-state next-state and registered-output logic.
  always_comb begin
    fsm_d     = fsm_q;
    frame_d   = frame_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    is_dead_d = is_dead_q;
    invuln_d  = invuln_q;
    alive_d   = alive_q;
    case (fsm_q)
      ALIVE: begin
        is_dead_d = 1'b0;
        invuln_d  = 1'b0;
        if (hit) begin
          fsm_d   = DYING;
          phase_d = '0;
          alive_d = 1'b0;
        end else begin
          frame_d = walk_frame;
          dir_d   = walk_dir;
          alive_d = 1'b1;
        end
      end
      DYING: begin
        alive_d  = 1'b0;
        invuln_d = 1'b0;
        if (phase_q == DEATH_END) begin
          fsm_d     = DEAD;
          is_dead_d = 1'b1;
        end else if (tick) begin
          is_dead_d = ~is_dead_q;
          phase_d   = phase_q + PW'(1);
        end
      end
      DEAD: begin
        if (revive) begin
          fsm_d     = SPAWN;
          phase_d   = '0;
          frame_d   = '0;
          is_dead_d = 1'b0;
          invuln_d  = 1'b1;
          alive_d   = 1'b1;
        end else begin
          is_dead_d = 1'b1;
          invuln_d  = 1'b0;
          alive_d   = 1'b0;
        end
      end
      SPAWN: begin
        frame_d   = walk_frame;
        dir_d     = walk_dir;
        is_dead_d = 1'b0;
        invuln_d  = 1'b1;
        alive_d   = 1'b1;
        // Leave on the edge of the final tick so invuln drops with it.
        if (tick) begin
          if (phase_q == SPAWN_LAST) begin
            fsm_d    = ALIVE;
            invuln_d = 1'b0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      default: begin
        fsm_d = ALIVE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= ALIVE;
      frame_q   <= '0;
      dir_q     <= DIR_DOWN;
      phase_q   <= '0;
      is_dead_q <= 1'b0;
      invuln_q  <= 1'b0;
      alive_q   <= 1'b1;
    end else begin
      fsm_q     <= fsm_d;
      frame_q   <= frame_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      is_dead_q <= is_dead_d;
      invuln_q  <= invuln_d;
      alive_q   <= alive_d;
    end
  end

  assign state   = frame_index(dir_q, frame_q);
  assign is_dead = is_dead_q;
  assign invuln  = invuln_q;
  assign alive   = alive_q;

endmodule
